// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter register and incrementer for the fetch unit.
// Next-PC priority is exception, jump, branch, stall, then sequential advance.
// Each redirect is followed by REDIRECT_BUBBLES invalid fetch cycles.
// Optional feature macro: PC_ALIGN_CHECK_EN. When it is defined, misaligned
// jump and branch targets are replaced by EXC_VECTOR and MisalignFault pulses.
module pc_sequencer #(
  parameter int unsigned       WIDTH            = 32,
  parameter int unsigned       INC              = 4,
  parameter logic [WIDTH-1:0]  RESET_VECTOR     = 32'h0000_0000,
  parameter logic [WIDTH-1:0]  EXC_VECTOR       = 32'h0000_0080,
  parameter int unsigned       REDIRECT_BUBBLES = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic             BranchTaken,
  input  logic [WIDTH-1:0] BranchTarget,
  input  logic             Jump,
  input  logic [WIDTH-1:0] JumpTarget,
  input  logic             Exception,
  output logic [WIDTH-1:0] PCResult,
  output logic [WIDTH-1:0] PCAddResult,
  output logic             FetchValid,
  output logic             Redirected,
  output logic             Wrapped
`ifdef PC_ALIGN_CHECK_EN
  ,
  output logic             MisalignFault
`endif
);

  typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_BUBBLE = 2'd2} state_t;

  localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
  localparam logic [2:0]       BUB_LOAD = 3'(REDIRECT_BUBBLES);

  // Parameter sanity: a zero or oversized increment, or too many bubbles,
  // cannot be represented by this datapath.
  if (INC == 0 || (INC >> WIDTH) != 0) begin : g_bad_inc
    $error("pc_sequencer: INC must be nonzero and below 2**WIDTH");
  end
  if (REDIRECT_BUBBLES > 7) begin : g_bad_bubbles
    $error("pc_sequencer: REDIRECT_BUBBLES must be 0..7");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             redirected_q, redirected_d;
  logic             wrapped_q, wrapped_d;
  logic             redirect_s;
  logic [WIDTH-1:0] target_s;
  logic [WIDTH-1:0] redirect_pc_s;
  logic [WIDTH:0]   sum_s;

`ifdef PC_ALIGN_CHECK_EN
  localparam int unsigned      ALIGN_BITS = $clog2(INC);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);
  logic misalign_q, misalign_d;
  logic misalign_s;
`endif

  // Incrementer with carry-out so a wrap past the top of the address space is visible.
  assign sum_s = {1'b0, pc_q} + {1'b0, INC_W};

  // Select the redirect target by priority; exception targets are never alignment-checked.
  always_comb begin
    redirect_s = Exception | Jump | BranchTaken;
    if (Exception) begin
      target_s = EXC_VECTOR;
    end else if (Jump) begin
      target_s = JumpTarget;
    end else if (BranchTaken) begin
      target_s = BranchTarget;
    end else begin
      target_s = pc_q;
    end
`ifdef PC_ALIGN_CHECK_EN
    misalign_s    = ~Exception & (Jump | BranchTaken) & ((target_s & ALIGN_MASK) != '0);
    redirect_pc_s = misalign_s ? EXC_VECTOR : target_s;
`else
    redirect_pc_s = target_s;
`endif
  end

  // Next-state logic: boot, redirect, bubble countdown, stall or sequential advance.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cnt_d        = cnt_q;
    redirected_d = 1'b0;
    wrapped_d    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
    misalign_d   = 1'b0;
`endif
    case (state_q)
      S_BOOT: begin
        // First edge out of reset only starts the machine; redirects are ignored.
        state_d = S_RUN;
      end
      S_RUN, S_BUBBLE: begin
        if (redirect_s) begin
          pc_d         = redirect_pc_s;
          redirected_d = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
          misalign_d   = misalign_s;
`endif
          if (REDIRECT_BUBBLES > 0) begin
            state_d = S_BUBBLE;
            cnt_d   = BUB_LOAD;
          end else begin
            state_d = S_RUN;
            cnt_d   = 3'd0;
          end
        end else if (state_q == S_BUBBLE) begin
          // Bubbles count down regardless of Stall; PC holds the target.
          cnt_d = cnt_q - 3'd1;
          if (cnt_q <= 3'd1) begin
            state_d = S_RUN;
          end else begin
            state_d = S_BUBBLE;
          end
        end else if (!Stall) begin
          pc_d      = sum_s[WIDTH-1:0];
          wrapped_d = sum_s[WIDTH];
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        state_d = S_BOOT;
        pc_d    = RESET_VECTOR;
        cnt_d   = 3'd0;
      end
    endcase
  end

  // State, PC and pulse registers; reset discards any pending bubble or stall.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_VECTOR;
      cnt_q        <= 3'd0;
      redirected_q <= 1'b0;
      wrapped_q    <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      cnt_q        <= cnt_d;
      redirected_q <= redirected_d;
      wrapped_q    <= wrapped_d;
`ifdef PC_ALIGN_CHECK_EN
      misalign_q   <= misalign_d;
`endif
    end
  end

  assign PCResult    = pc_q;
  assign PCAddResult = sum_s[WIDTH-1:0];
  assign FetchValid  = (state_q == S_RUN) & ~Stall;
  assign Redirected  = redirected_q;
  assign Wrapped     = wrapped_q;
`ifdef PC_ALIGN_CHECK_EN
  assign MisalignFault = misalign_q;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: a 32-bit instance with one bubble and an 8-bit
// instance with three bubbles share all stimulus. A small reference model
// produces expected outputs that are queued when stimulus is driven and
// compared after the clock edge.
module tb_pc_sequencer;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, Jump, Exception;
  logic [31:0] bt, jt;
  logic [31:0] pc_a, add_a;
  logic        fv_a, rd_a, wr_a;
  logic [7:0]  pc_b, add_b;
  logic        fv_b, rd_b, wr_b;
`ifdef PC_ALIGN_CHECK_EN
  logic        mf_a, mf_b;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 Clk = ~Clk;

  pc_sequencer dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(bt),
    .Jump(Jump), .JumpTarget(jt), .Exception(Exception),
    .PCResult(pc_a), .PCAddResult(add_a), .FetchValid(fv_a),
    .Redirected(rd_a), .Wrapped(wr_a)
`ifdef PC_ALIGN_CHECK_EN
    , .MisalignFault(mf_a)
`endif
  );

  pc_sequencer #(.WIDTH(8), .INC(4), .RESET_VECTOR(8'h00), .EXC_VECTOR(8'h80),
                 .REDIRECT_BUBBLES(3)) dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall),
    .BranchTaken(BranchTaken), .BranchTarget(bt[7:0]),
    .Jump(Jump), .JumpTarget(jt[7:0]), .Exception(Exception),
    .PCResult(pc_b), .PCAddResult(add_b), .FetchValid(fv_b),
    .Redirected(rd_b), .Wrapped(wr_b)
`ifdef PC_ALIGN_CHECK_EN
    , .MisalignFault(mf_b)
`endif
  );

  // Reference model state: st 0=BOOT, 1=RUN, 2=BUBBLE.
  typedef struct {
    int          st;
    logic [31:0] pc;
    int          cnt;
    logic        rd, wr, mf;
  } ms_t;

  typedef struct {
    string       tag;
    logic [31:0] pa, aa, pb, ab;
    logic        fa, ra, wa, ma, fb, rb, wb, mb;
  } exp_t;

  ms_t  m_a, m_b;
  exp_t sb[$];

  function automatic ms_t m_reset();
    ms_t r;
    r.st = 0; r.pc = 32'h0; r.cnt = 0; r.rd = 1'b0; r.wr = 1'b0; r.mf = 1'b0;
    return r;
  endfunction

  function automatic ms_t m_step(ms_t s, logic [31:0] mask, int bub);
    ms_t         n = s;
    logic [32:0] sum;
    logic [31:0] tgt;
    logic        bad = 1'b0;
    n.rd = 1'b0; n.wr = 1'b0; n.mf = 1'b0;
    if (Exception)  tgt = 32'h80;
    else if (Jump) begin tgt = jt; bad = (jt[1:0] != 2'b00); end
    else begin tgt = bt; bad = (bt[1:0] != 2'b00); end
`ifdef PC_ALIGN_CHECK_EN
    if (bad) tgt = 32'h80;
`else
    bad = 1'b0;
`endif
    if (s.st == 0) begin
      n.st = 1;
    end else if (Exception || Jump || BranchTaken) begin
      n.pc = tgt & mask; n.rd = 1'b1; n.mf = bad;
      n.st = (bub > 0) ? 2 : 1; n.cnt = bub;
    end else if (s.st == 2) begin
      n.cnt = s.cnt - 1;
      if (s.cnt == 1) n.st = 1;
    end else if (!Stall) begin
      sum  = {1'b0, s.pc} + 33'd4;
      n.wr = (sum > {1'b0, mask});
      n.pc = sum[31:0] & mask;
    end
    return n;
  endfunction

  task automatic push_exp(string tag);
    exp_t e;
    e.tag = tag;
    e.pa = m_a.pc; e.aa = m_a.pc + 32'd4; e.fa = (m_a.st == 1) && !Stall;
    e.ra = m_a.rd; e.wa = m_a.wr; e.ma = m_a.mf;
    e.pb = m_b.pc; e.ab = (m_b.pc + 32'd4) & 32'hFF; e.fb = (m_b.st == 1) && !Stall;
    e.rb = m_b.rd; e.wb = m_b.wr; e.mb = m_b.mf;
    sb.push_back(e);
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pop_cmp();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({e.tag, ".pc_a"},  pc_a, e.pa);
    chk({e.tag, ".add_a"}, add_a, e.aa);
    chk({e.tag, ".fv_a"},  32'(fv_a), 32'(e.fa));
    chk({e.tag, ".rd_a"},  32'(rd_a), 32'(e.ra));
    chk({e.tag, ".wr_a"},  32'(wr_a), 32'(e.wa));
    chk({e.tag, ".pc_b"},  32'(pc_b), e.pb);
    chk({e.tag, ".add_b"}, 32'(add_b), e.ab);
    chk({e.tag, ".fv_b"},  32'(fv_b), 32'(e.fb));
    chk({e.tag, ".rd_b"},  32'(rd_b), 32'(e.rb));
    chk({e.tag, ".wr_b"},  32'(wr_b), 32'(e.wb));
`ifdef PC_ALIGN_CHECK_EN
    chk({e.tag, ".mf_a"},  32'(mf_a), 32'(e.ma));
    chk({e.tag, ".mf_b"},  32'(mf_b), 32'(e.mb));
`endif
  endtask

  // Drive one cycle of stimulus, queue the model's post-edge expectation, compare after the edge.
  task automatic step(string tag, logic s, logic b, logic [31:0] btv,
                      logic j, logic [31:0] jtv, logic e);
    Stall = s; BranchTaken = b; bt = btv; Jump = j; jt = jtv; Exception = e;
    if (Reset) begin
      m_a = m_step(m_a, 32'hFFFF_FFFF, 1);
      m_b = m_step(m_b, 32'h0000_00FF, 3);
    end else begin
      m_a = m_reset();
      m_b = m_reset();
    end
    push_exp(tag);
    @(posedge Clk);
    #1;
    pop_cmp();
  endtask

  task automatic idle(string tag, int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  // Asynchronous reset assertion: outputs must change without a clock edge.
  task automatic reset_now(string tag);
    Reset = 1'b0;
    m_a = m_reset();
    m_b = m_reset();
    push_exp(tag);
    #1;
    pop_cmp();
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0; Exception = 1'b0;
    bt = 32'h0; jt = 32'h0;
    m_a = m_reset();
    m_b = m_reset();
    #2;
    reset_now("rst_async");
    @(posedge Clk);
    #1;
    // Reset held low for three cycles, then release; the boot edge ignores a jump.
    for (int i = 0; i < 3; i++) step("rst_hold", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    Reset = 1'b1;
    step("boot_jump_ignored", 1'b0, 1'b0, 32'h0, 1'b1, 32'h300, 1'b0);
    idle("run_free", 4);
    chk("lit_pc_a_0x10", pc_a, 32'h10);

    // Stall holds the PC, then a branch overrides the stall.
    step("stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("stall", 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    step("stall_branch", 1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    chk("lit_branch_pc_a", pc_a, 32'h200);
    idle("post_branch", 2);
    chk("lit_branch_next_a", pc_a, 32'h204);
    idle("post_branch", 1);

    // Exception, jump and branch together: exception wins.
    step("priority", 1'b0, 1'b1, 32'h10, 1'b1, 32'h20, 1'b1);
    chk("lit_prio_pc_b", 32'(pc_b), 32'h80);
    idle("post_priority", 3);
    chk("lit_prio_fv_b", 32'(fv_b), 32'h1);
    idle("post_priority", 1);
    chk("lit_prio_next_b", 32'(pc_b), 32'h84);

    // Jump near the top, re-jump mid-bubble (counter reload), then wrap.
    step("jump_top", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle("bubble", 1);
    step("jump_reload", 1'b0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    idle("wrap", 4);
    chk("lit_wrap_b", 32'(wr_b), 32'h1);
    idle("wrap_after", 1);
    step("jump_zero", 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 1'b0);
    idle("after_jump_zero", 4);

    // Misaligned jump target.
    step("jump_misalign", 1'b0, 1'b0, 32'h0, 1'b1, 32'h102, 1'b0);
`ifdef PC_ALIGN_CHECK_EN
    chk("lit_misalign_pc_a", pc_a, 32'h80);
`else
    chk("lit_misalign_pc_a", pc_a, 32'h102);
`endif
    idle("after_misalign", 4);

    // Reset during the second bubble cycle of the three-bubble instance.
    step("jump_40", 1'b0, 1'b0, 32'h0, 1'b1, 32'h40, 1'b0);
    idle("bubble_40", 1);
    #3;
    reset_now("rst_mid_bubble");
    chk("lit_rst_mid_pc_b", 32'(pc_b), 32'h0);
    @(posedge Clk);
    #1;
    step("rst_hold2", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    Reset = 1'b1;
    idle("reboot", 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
